// File: rtl/de_grant_pkg.sv
// ---------------------------------------------------------------------------
// de_grant_pkg
// Shared definitions for the 3:8 grant decoder slice.
//   state_t        : FSM encoding (IDLE / GRANT / RECOVER)
//   DEFAULT_*      : default parameter values for the decoder and interface
//   idx_to_onehot  : 3-bit channel index to 8-bit one-hot grant vector
// ---------------------------------------------------------------------------
package de_grant_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam int DEFAULT_TIMEOUT = 15;
    localparam int DEFAULT_CNT_W   = 8;

    // A shift of a single set bit can only ever produce one hot line, which
    // is what keeps the grant output from going multi-hot.
    function automatic logic [7:0] idx_to_onehot(input logic [2:0] idx);
        idx_to_onehot = 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/de_38_grant_if.sv
// ---------------------------------------------------------------------------
// de_38_grant_if
// Handshake and grant bundle between an index producer and the decoder.
//   in_valid / in_ready / in_idx : index handshake (producer -> decoder)
//   done                         : granted channel finished
//   grant                        : one-hot grant (decoder -> channels)
//   busy, timeout_err, grant_cnt : status / debug from the decoder
// Modports: master = producer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface de_38_grant_if
    import de_grant_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_idx;
    logic             done;
    logic [7:0]       grant;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output in_valid,
        output in_idx,
        output done,
        input  in_ready,
        input  grant,
        input  busy,
        input  timeout_err,
        input  grant_cnt
    );

    modport slave (
        input  in_valid,
        input  in_idx,
        input  done,
        output in_ready,
        output grant,
        output busy,
        output timeout_err,
        output grant_cnt
    );

endinterface

// File: rtl/de_38_grant_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low clear
//   en    : count one event this cycle
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled events; once every bit is set further events are dropped
    // so a long-running debug count never rolls back to a small number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/de_38_grant.sv
// ---------------------------------------------------------------------------
// de_38_grant
// Sequential 3:8 decoder: accepts a channel index over valid/ready, holds the
// matching one-hot grant until the channel reports done or TIMEOUT cycles
// pass, then spends one recovery cycle before taking the next index.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : de_38_grant_if.slave (in_valid, in_ready, in_idx, done, grant,
//           busy, timeout_err, grant_cnt)
// Parameters: TIMEOUT (1..255) max grant length, CNT_W debug counter width.
// ---------------------------------------------------------------------------
module de_38_grant
    import de_grant_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    de_38_grant_if.slave bus
);

    localparam logic [7:0] HOLD_LAST = 8'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [7:0]       hold_cnt;
    logic [7:0]       grant_q;
    logic             timeout_q;
    logic             accept;
    logic             done_hit;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;

    // Event decode shared by the FSM and the datapath. done beats the timeout
    // when both land on the same edge, so timeout_hit is masked by done.
    assign accept      = bus.in_valid && (state == IDLE);
    assign done_hit    = (state == GRANT) && bus.done;
    assign timeout_hit = (state == GRANT) && !bus.done && (hold_cnt == HOLD_LAST);

    // State register. Reset parks the FSM in RECOVER so the block reports
    // busy and refuses indices until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RECOVER;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RECOVER is always a single cycle; the unused encoding
    // falls into RECOVER so a corrupted state heals through the normal path.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (done_hit || timeout_hit) begin
                    state_next = RECOVER;
                end
            end
            RECOVER: begin
                state_next = IDLE;
            end
            default: begin
                state_next = RECOVER;
            end
        endcase
    end

    // Unregistered status outputs decoded straight from the state, so that
    // in_ready and busy follow reset immediately along with the state.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.busy     = 1'b1;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            default: begin
                bus.in_ready = 1'b0;
                bus.busy     = 1'b1;
            end
        endcase
    end

    // Registered grant, timeout pulse and hold counter. The hold counter is
    // zero in the first grant cycle, so reaching TIMEOUT-1 means the grant
    // has been visible for exactly TIMEOUT cycles when it is dropped.
    // timeout_err defaults low every edge, which makes it a one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= 8'h00;
            timeout_q <= 1'b0;
            hold_cnt  <= 8'h00;
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    grant_q <= 8'h00;
                    if (accept) begin
                        grant_q  <= idx_to_onehot(bus.in_idx);
                        hold_cnt <= 8'h00;
                    end
                end
                GRANT: begin
                    hold_cnt <= hold_cnt + 8'd1;
                    if (done_hit) begin
                        grant_q <= 8'h00;
                    end else if (timeout_hit) begin
                        grant_q   <= 8'h00;
                        timeout_q <= 1'b1;
                    end
                end
                default: begin
                    grant_q <= 8'h00;
                end
            endcase
        end
    end

    // Debug count of grants that ended with done; timeouts are not counted.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_grant_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (done_hit),
        .count (cnt)
    );

    assign bus.grant       = grant_q;
    assign bus.timeout_err = timeout_q;
    assign bus.grant_cnt   = cnt;

endmodule

// File: tb/tb_de_38_grant.sv
// ---------------------------------------------------------------------------
// tb_de_38_grant
// Directed bench for de_38_grant. Two instances run the same stimulus: one
// with an 8-bit grant counter and one with a 2-bit counter to see it saturate.
// ---------------------------------------------------------------------------
module tb_de_38_grant;

    logic clk;
    logic rst_n;

    int check_count;
    int fail_count;

    de_38_grant_if #(.CNT_W(8)) bus8 ();
    de_38_grant_if #(.CNT_W(2)) bus2 ();

    de_38_grant #(
        .TIMEOUT (15),
        .CNT_W   (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    de_38_grant #(
        .TIMEOUT (15),
        .CNT_W   (2)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [2:0] idx, input logic dn);
        bus8.in_valid = valid;
        bus8.in_idx   = idx;
        bus8.done     = dn;
        bus2.in_valid = valid;
        bus2.in_idx   = idx;
        bus2.done     = dn;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic [7:0] grant,
                            input logic rdy, input logic bsy, input logic terr,
                            input logic [7:0] cnt8, input logic [1:0] cnt2);
        checkOutput({tag, ".grant"},    32'(bus8.grant),       32'(grant));
        checkOutput({tag, ".in_ready"}, 32'(bus8.in_ready),    32'(rdy));
        checkOutput({tag, ".busy"},     32'(bus8.busy),        32'(bsy));
        checkOutput({tag, ".tout"},     32'(bus8.timeout_err), 32'(terr));
        checkOutput({tag, ".cnt8"},     32'(bus8.grant_cnt),   32'(cnt8));
        checkOutput({tag, ".cnt2"},     32'(bus2.grant_cnt),   32'(cnt2));
        checkOutput({tag, ".sat_grant"}, 32'(bus2.grant),      32'(grant));
    endtask

    initial begin
        check_count = 0;
        fail_count  = 0;
        rst_n       = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0);

        // Reset held over two edges, then release between edges.
        repeat (2) @(posedge clk);
        #3;
        checkAll("reset", 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        rst_n = 1'b1;
        step();
        checkAll("idle_after_reset", 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);

        // Index 5 accepted, done raised in the third grant cycle.
        applyStimulus(1'b1, 3'd5, 1'b0);
        step();
        checkAll("g5_c1", 8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        applyStimulus(1'b0, 3'd0, 1'b0);
        step();
        checkAll("g5_c2", 8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        step();
        checkAll("g5_c3", 8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        applyStimulus(1'b0, 3'd0, 1'b1);
        step();
        checkAll("g5_recover", 8'h00, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        step();
        checkAll("g5_idle", 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);

        // Index 0 with no done: grant lasts exactly 15 cycles then times out.
        applyStimulus(1'b1, 3'd0, 1'b0);
        step();
        checkAll("to_c1", 8'h01, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        for (int k = 2; k <= 15; k++) begin
            step();
            checkOutput($sformatf("to_c%0d.grant", k), 32'(bus8.grant), 32'h01);
            checkOutput($sformatf("to_c%0d.tout", k), 32'(bus8.timeout_err), 32'h0);
        end
        step();
        checkAll("to_drop", 8'h00, 1'b0, 1'b1, 1'b1, 8'd1, 2'd1);
        step();
        checkAll("to_idle", 8'h00, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1);

        // Index 2, done arrives in the cycle the hold counter reaches 14.
        applyStimulus(1'b1, 3'd2, 1'b0);
        step();
        checkAll("race_c1", 8'h04, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        repeat (14) step();
        checkAll("race_c15", 8'h04, 1'b0, 1'b1, 1'b0, 8'd1, 2'd1);
        applyStimulus(1'b0, 3'd0, 1'b1);
        step();
        checkAll("race_end", 8'h00, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
        applyStimulus(1'b0, 3'd0, 1'b0);
        step();
        checkAll("race_idle", 8'h00, 1'b1, 1'b0, 1'b0, 8'd2, 2'd2);

        // Back-to-back with in_valid and done held high: done in IDLE is
        // ignored, the next index is taken on the first IDLE cycle, and the
        // 2-bit counter sticks at 3.
        applyStimulus(1'b1, 3'd1, 1'b1);
        step();
        checkAll("b2b_g1", 8'h02, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);
        step();
        checkAll("b2b_r1", 8'h00, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3);
        applyStimulus(1'b1, 3'd7, 1'b1);
        step();
        checkAll("b2b_idle", 8'h00, 1'b1, 1'b0, 1'b0, 8'd3, 2'd3);
        step();
        checkAll("b2b_g2", 8'h80, 1'b0, 1'b1, 1'b0, 8'd3, 2'd3);
        step();
        checkAll("b2b_r2", 8'h00, 1'b0, 1'b1, 1'b0, 8'd4, 2'd3);
        applyStimulus(1'b0, 3'd0, 1'b0);
        step();
        checkAll("b2b_end", 8'h00, 1'b1, 1'b0, 1'b0, 8'd4, 2'd3);

        // Reset mid-grant: outputs drop without waiting for a clock edge.
        applyStimulus(1'b1, 3'd7, 1'b0);
        step();
        checkAll("rst_g", 8'h80, 1'b0, 1'b1, 1'b0, 8'd4, 2'd3);
        applyStimulus(1'b0, 3'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkAll("rst_async", 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        step();
        checkAll("rst_held", 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 2'd0);
        #3;
        rst_n = 1'b1;
        #1;
        checkOutput("rst_release.in_ready", 32'(bus8.in_ready), 32'h0);
        step();
        checkAll("rst_idle", 8'h00, 1'b1, 1'b0, 1'b0, 8'd0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/de_38_grant.md
Name: de_38_grant

Overview:
Sequential 3:8 decoder that converts an encoded 3-bit channel index into a held one-hot grant. It is the consumer-side counterpart of the 8:3 priority encoder used for request arbitration.
- Accepts an index over a valid/ready handshake.
- Asserts the matching grant line until the granted channel signals done or a timeout expires.
- Inserts one recovery cycle before accepting the next index.
- Keeps a saturating count of completed grants for debug.

Parameters:
TIMEOUT, 15, max cycles a grant is held without done; legal range 1..255.
CNT_W, 8, width of the completed-grant counter.

Ports:
clk  input  1  clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_idx is valid this cycle.
in_ready  output  1  block can accept an index this cycle.
in_idx  input  3  encoded channel index, 0..7.
done  input  1  granted channel finished; sampled only in GRANT.
grant  output  8  one-hot grant, bit in_idx set; all-zero when not granting.
busy  output  1  high in GRANT and RECOVER.
timeout_err  output  1  one-cycle pulse when a grant is dropped by timeout.
grant_cnt  output  CNT_W  saturating count of grants ended by done.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous and active-low. Asserting rst_n low takes effect immediately without a clock edge.
  - Reset values: state=RECOVER, grant=0, timeout_err=0, grant_cnt=0, hold counter=0.
  - Hence in_ready=0 and busy=1 while in reset.
  - The first rising edge after release moves to IDLE.
- All outputs are registered, except in_ready and busy, which decode state directly.
- States: IDLE, GRANT, RECOVER.
- IDLE:
  - in_ready=1, grant=0.
  - On edge with in_valid&&in_ready: grant <= 1<<in_idx, hold counter <= 0, go to GRANT.
  - Latency: grant is visible in the cycle after acceptance.
  - done in IDLE is ignored.
- GRANT:
  - in_ready=0; grant held constant; hold counter increments each cycle.
  - If done=1: grant <= 0, grant_cnt <= grant_cnt+1 (saturating at all-ones, no wrap), go to RECOVER.
  - Else if hold counter == TIMEOUT-1: grant <= 0, timeout_err <= 1 for exactly one cycle, go to RECOVER. grant_cnt is unchanged.
  - done and timeout on the same edge: done wins, no timeout_err.
  - Result: grant is high for a minimum of 1 cycle and a maximum of exactly TIMEOUT cycles.
- RECOVER:
  - grant=0, in_ready=0, busy=1.
  - Lasts exactly one cycle, then IDLE.
  - in_valid held high across RECOVER is accepted on the first IDLE cycle.
- Back-to-back throughput: one grant per (hold cycles + 2) cycles minimum.
- Reset mid-GRANT: grant drops to 0 immediately (asynchronous); no timeout_err or count update.
- grant is never multi-hot; it is always zero outside GRANT.

Decomposition:
- Shared package de_grant_pkg:
  - State enum constants: IDLE=2'd0, GRANT=2'd1, RECOVER=2'd2.
  - Default TIMEOUT/CNT_W localparams.
  - Function idx_to_onehot(3-bit) -> 8-bit.
- One natural sub-module: sat_counter (parameterised width, enable, async active-low clear), instantiated for grant_cnt.
- The hold counter stays inline.

Test Plan:
- Reset release: after rst_n rises, first edge -> in_ready=1, grant=8'h00, grant_cnt=0, timeout_err=0.
- Accept in_idx=3'd5 with in_valid=1 -> next cycle grant=8'h20, busy=1, in_ready=0. Then done=1 after 3 grant cycles -> grant=8'h00, grant_cnt=1, RECOVER for 1 cycle, then in_ready=1.
- No done, TIMEOUT=15, in_idx=3'd0 -> grant=8'h01 held exactly 15 cycles, then grant=8'h00 with timeout_err=1 for one cycle; grant_cnt unchanged.
- done asserted in the same cycle the hold counter reaches 14 -> no timeout_err; grant_cnt increments.
- Reset mid-GRANT: grant=8'h80 active, rst_n low mid-cycle -> grant=8'h00 immediately; in_ready=0 until the first edge after release.
- Saturation, CNT_W=2: four done-terminated grants -> grant_cnt reads 1, 2, 3, 3. Also cover in_valid held high through RECOVER -> next index accepted on the first IDLE cycle.
